riscv_core_div_unit: RTL

Iterative radix-2^k non-restoring integer divider for the RV64 M-extension execute stage, successor to the single-mode unsigned divider. Adds signed/unsigned DIV/REM selection, RISC-V divide-by-zero and overflow semantics, a configurable number of quotient bits per cycle, optional 32-bit word ops, flush, and a valid/ready result handshake.

---
 rtl/riscv_core_div_unit.sv | 286 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/riscv_core_div_unit.sv
// riscv_core_div_unit
// Iterative radix-2^BITS_PER_CYCLE non-restoring integer divider for the RV64
// M-extension execute stage. Supports DIV/DIVU/REM/REMU with RISC-V
// divide-by-zero and signed-overflow results, flush, and a valid/ready result
// handshake.
//
// Optional feature macro: RISCV_CORE_DIV_UNIT_WORD_OP_EN
//   defined   -> i_div_unit_word selects 32-bit W ops (results sign-extended)
//   undefined -> i_div_unit_word is ignored and every op is XLEN wide
//
// Ports
//   i_div_unit_clk           clock, rising edge
//   i_div_unit_rstn          asynchronous active-low reset
//   i_div_unit_valid         request valid
//   o_div_unit_ready         request accepted when high (IDLE only)
//   i_div_unit_op            00 DIV, 01 DIVU, 10 REM, 11 REMU
//   i_div_unit_word          32-bit W operation select
//   i_div_unit_dividend      dividend
//   i_div_unit_divisor       divisor
//   i_div_unit_flush         synchronous abort to IDLE
//   o_div_unit_busy          high in any state other than IDLE
//   o_div_unit_valid         result valid (DONE only)
//   i_div_unit_result_ready  consumer accepts the result
//   o_div_unit_result        quotient or remainder, 0 while not valid
module riscv_core_div_unit #(
  parameter int XLEN           = 64,
  parameter int BITS_PER_CYCLE = 2
) (
  input  logic            i_div_unit_clk,
  input  logic            i_div_unit_rstn,
  input  logic            i_div_unit_valid,
  output logic            o_div_unit_ready,
  input  logic [1:0]      i_div_unit_op,
  input  logic            i_div_unit_word,
  input  logic [XLEN-1:0] i_div_unit_dividend,
  input  logic [XLEN-1:0] i_div_unit_divisor,
  input  logic            i_div_unit_flush,
  output logic            o_div_unit_busy,
  output logic            o_div_unit_valid,
  input  logic            i_div_unit_result_ready,
  output logic [XLEN-1:0] o_div_unit_result
);

  localparam int CNT_W = $clog2(XLEN / BITS_PER_CYCLE + 1);
  localparam logic [CNT_W-1:0] CNT_LAST_FULL = CNT_W'(XLEN / BITS_PER_CYCLE - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PREP   = 3'd1,
    S_DIVIDE = 3'd2,
    S_POST   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t            r_state;
  logic [1:0]        r_op;
  logic [XLEN-1:0]   r_dividend;
  logic [XLEN-1:0]   r_divisor;
  logic [XLEN:0]     r_a;
  logic [XLEN-1:0]   r_q;
  logic [XLEN:0]     r_m;
  logic              r_neg_q;
  logic              r_neg_r;
  logic [CNT_W-1:0]  r_cnt;
  logic [XLEN-1:0]   r_result;
  logic              r_ready;
  logic              r_busy;
  logic              r_valid;

  logic              w_signed;
  logic              w_sign_a;
  logic              w_sign_b;
  logic              w_div_zero;
  logic              w_overflow;
  logic [XLEN-1:0]   w_a_ext;
  logic [XLEN-1:0]   w_q_init;
  logic [XLEN:0]     w_m_init;
  logic [CNT_W-1:0]  w_last;
  logic [XLEN-1:0]   w_special;
  logic [2*XLEN:0]   w_iter;
  logic [XLEN-1:0]   w_a_fix;
  logic [XLEN-1:0]   w_q_mag;
  logic [XLEN-1:0]   w_r_mag;
  logic [XLEN-1:0]   w_sel;
  logic [XLEN-1:0]   w_post_result;

`ifdef RISCV_CORE_DIV_UNIT_WORD_OP_EN
  localparam logic [CNT_W-1:0] CNT_LAST_WORD = CNT_W'(32 / BITS_PER_CYCLE - 1);
  logic        r_word;
  logic [31:0] w_mag_a32;
  logic [31:0] w_mag_b32;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return XLEN'($signed(v));
  endfunction
`else
  logic w_unused_word;
  assign w_unused_word = i_div_unit_word;
`endif

  // BITS_PER_CYCLE chained non-restoring steps on {A,Q}; returns {A,Q}.
  function automatic logic [2*XLEN:0] div_iter(input logic [XLEN:0]   a,
                                               input logic [XLEN-1:0] q,
                                               input logic [XLEN:0]   m);
    logic [XLEN:0]   v_a;
    logic [XLEN-1:0] v_q;
    logic [XLEN:0]   v_sh;
    v_a = a;
    v_q = q;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      v_sh = {v_a[XLEN-1:0], v_q[XLEN-1]};
      if (v_a[XLEN]) begin
        v_a = v_sh + m;
      end else begin
        v_a = v_sh - m;
      end
      v_q = {v_q[XLEN-2:0], ~v_a[XLEN]};
    end
    return {v_a, v_q};
  endfunction

  assign w_signed = ~r_op[0];
  assign w_iter   = div_iter(r_a, r_q, r_m);

  // Operand preparation: magnitudes, signs and special-case detection.
  // Word ops park the 32-bit dividend in the top of Q so the shared XLEN
  // datapath consumes exactly its 32 bits in 32/BITS_PER_CYCLE cycles.
  always_comb begin
    w_sign_a   = w_signed & r_dividend[XLEN-1];
    w_sign_b   = w_signed & r_divisor[XLEN-1];
    w_q_init   = w_sign_a ? ({XLEN{1'b0}} - r_dividend) : r_dividend;
    w_m_init   = {1'b0, (w_sign_b ? ({XLEN{1'b0}} - r_divisor) : r_divisor)};
    w_div_zero = (r_divisor == {XLEN{1'b0}});
    w_overflow = w_signed & (r_dividend == {1'b1, {(XLEN-1){1'b0}}}) &
                 (r_divisor == {XLEN{1'b1}});
    w_a_ext    = r_dividend;
    w_last     = CNT_LAST_FULL;
`ifdef RISCV_CORE_DIV_UNIT_WORD_OP_EN
    if (r_word) begin
      w_sign_a   = w_signed & r_dividend[31];
      w_sign_b   = w_signed & r_divisor[31];
      w_mag_a32  = w_sign_a ? (32'd0 - r_dividend[31:0]) : r_dividend[31:0];
      w_mag_b32  = w_sign_b ? (32'd0 - r_divisor[31:0]) : r_divisor[31:0];
      w_q_init   = XLEN'(w_mag_a32) << (XLEN - 32);
      w_m_init   = (XLEN+1)'(w_mag_b32);
      w_div_zero = (r_divisor[31:0] == 32'd0);
      w_overflow = w_signed & (r_dividend[31:0] == 32'h8000_0000) &
                   (r_divisor[31:0] == 32'hFFFF_FFFF);
      w_a_ext    = sext32(r_dividend[31:0]);
      w_last     = CNT_LAST_WORD;
    end else begin
      w_mag_a32 = 32'd0;
      w_mag_b32 = 32'd0;
    end
`endif
  end

  // Special-case results: divide-by-zero takes priority over overflow.
  always_comb begin
    if (w_div_zero) begin
      w_special = r_op[1] ? w_a_ext : {XLEN{1'b1}};
    end else begin
      w_special = r_op[1] ? {XLEN{1'b0}} : w_a_ext;
    end
  end

  // Final result: remainder correction, sign fix-up and W-op sign extension.
  always_comb begin
    w_a_fix = r_a[XLEN] ? (r_a[XLEN-1:0] + r_m[XLEN-1:0]) : r_a[XLEN-1:0];
    w_q_mag = r_q;
    w_r_mag = w_a_fix;
`ifdef RISCV_CORE_DIV_UNIT_WORD_OP_EN
    if (r_word) begin
      w_q_mag = XLEN'(r_q[31:0]);
      w_r_mag = XLEN'(w_a_fix[31:0]);
    end else begin
      w_q_mag = r_q;
      w_r_mag = w_a_fix;
    end
`endif
    if (r_op[1]) begin
      w_sel = r_neg_r ? ({XLEN{1'b0}} - w_r_mag) : w_r_mag;
    end else begin
      w_sel = r_neg_q ? ({XLEN{1'b0}} - w_q_mag) : w_q_mag;
    end
    w_post_result = w_sel;
`ifdef RISCV_CORE_DIV_UNIT_WORD_OP_EN
    if (r_word) begin
      w_post_result = sext32(w_sel[31:0]);
    end else begin
      w_post_result = w_sel;
    end
`endif
  end

  // Control FSM and datapath registers; flags are registered with the state.
  always_ff @(posedge i_div_unit_clk or negedge i_div_unit_rstn) begin
    if (!i_div_unit_rstn) begin
      r_state    <= S_IDLE;
      r_op       <= 2'd0;
      r_dividend <= {XLEN{1'b0}};
      r_divisor  <= {XLEN{1'b0}};
      r_a        <= {(XLEN+1){1'b0}};
      r_q        <= {XLEN{1'b0}};
      r_m        <= {(XLEN+1){1'b0}};
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_cnt      <= {CNT_W{1'b0}};
      r_result   <= {XLEN{1'b0}};
      r_ready    <= 1'b1;
      r_busy     <= 1'b0;
      r_valid    <= 1'b0;
`ifdef RISCV_CORE_DIV_UNIT_WORD_OP_EN
      r_word     <= 1'b0;
`endif
    end else if (i_div_unit_flush) begin
      r_state <= S_IDLE;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_div_unit_valid) begin
            r_op       <= i_div_unit_op;
            r_dividend <= i_div_unit_dividend;
            r_divisor  <= i_div_unit_divisor;
`ifdef RISCV_CORE_DIV_UNIT_WORD_OP_EN
            r_word     <= i_div_unit_word;
`endif
            r_state    <= S_PREP;
            r_ready    <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        S_PREP: begin
          if (w_div_zero | w_overflow) begin
            r_result <= w_special;
            r_state  <= S_DONE;
            r_valid  <= 1'b1;
          end else begin
            r_a     <= {(XLEN+1){1'b0}};
            r_q     <= w_q_init;
            r_m     <= w_m_init;
            r_neg_q <= w_sign_a ^ w_sign_b;
            r_neg_r <= w_sign_a;
            r_cnt   <= {CNT_W{1'b0}};
            r_state <= S_DIVIDE;
          end
        end
        S_DIVIDE: begin
          {r_a, r_q} <= w_iter;
          r_cnt      <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
          if (r_cnt == w_last) begin
            r_state <= S_POST;
          end
        end
        S_POST: begin
          r_result <= w_post_result;
          r_state  <= S_DONE;
          r_valid  <= 1'b1;
        end
        S_DONE: begin
          if (i_div_unit_result_ready) begin
            r_state <= S_IDLE;
            r_valid <= 1'b0;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_valid <= 1'b0;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_div_unit_ready  = r_ready;
  assign o_div_unit_busy   = r_busy;
  assign o_div_unit_valid  = r_valid;
  assign o_div_unit_result = r_valid ? r_result : {XLEN{1'b0}};

endmodule
